// File: rtl/barrel_scan_ctrl_if.sv
// rtl/barrel_scan_ctrl_if.sv - coordinate beat stream between scan controller and transform pipeline
interface barrel_scan_ctrl_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  modport master (
    output m_tdata,
    output m_tvalid,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    output m_tready
  );
endinterface

// File: rtl/barrel_scan_ctrl.sv
// rtl/barrel_scan_ctrl.sv - raster coordinate generator with credit-limited in-flight tracking
module barrel_scan_ctrl #(
  parameter int X_MIN   = -540,
  parameter int X_MAX   = 539,
  parameter int Y_TOP   = 480,
  parameter int Y_BOT   = -479,
  parameter int CREDITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  barrel_scan_ctrl_if.master  m_axis,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic                retire,
  output logic                frame_start,
  output logic                frame_done,
  output logic                busy,
  output logic [5:0]          inflight,
  output logic                err_underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic signed [15:0] XMIN_C = 16'(X_MIN);
  localparam logic signed [15:0] XMAX_C = 16'(X_MAX);
  localparam logic signed [15:0] YTOP_C = 16'(Y_TOP);
  localparam logic signed [15:0] YBOT_C = 16'(Y_BOT);
  localparam logic [6:0]         CRED_C = 7'(CREDITS);

  state_t             state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic signed [15:0] y_q, y_d;
  logic               valid_q, valid_d;
  logic               fs_q, fs_d;
  logic               fd_q, fd_d;
  logic               stop_pending_q, stop_pending_d;
  logic               err_q, err_d;
  logic [5:0]         inflight_q, inflight_d;

  logic hs;
  logic ret_ok;
  logic last_beat;
  logic credit_ok;

  assign hs        = valid_q & m_axis.m_tready;
  assign ret_ok    = retire & (inflight_q != 6'd0);
  assign last_beat = (x_q == XMAX_C) && (y_q == YBOT_C);

  // Counting rule: handshake adds, retire subtracts, both together cancel.
  assign inflight_d = inflight_q + {5'd0, hs} - {5'd0, ret_ok};
  assign credit_ok  = ({1'b0, inflight_d} < CRED_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      x_q            <= XMIN_C;
      y_q            <= YTOP_C;
      valid_q        <= 1'b0;
      fs_q           <= 1'b0;
      fd_q           <= 1'b0;
      stop_pending_q <= 1'b0;
      err_q          <= 1'b0;
      inflight_q     <= 6'd0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      valid_q        <= valid_d;
      fs_q           <= fs_d;
      fd_q           <= fd_d;
      stop_pending_q <= stop_pending_d;
      err_q          <= err_d;
      inflight_q     <= inflight_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    valid_d        = valid_q;
    fs_d           = 1'b0;
    fd_d           = 1'b0;
    stop_pending_d = stop_pending_q;
    err_d          = err_q | (retire & (inflight_q == 6'd0));

    unique case (state_q)
      IDLE: begin
        valid_d        = 1'b0;
        stop_pending_d = 1'b0;
        if (start) begin
          state_d        = RUN;
          x_d            = XMIN_C;
          y_d            = YTOP_C;
          valid_d        = credit_ok;
          fs_d           = 1'b1;
          // start with stop in the same cycle runs exactly one frame
          stop_pending_d = stop;
        end
      end

      RUN: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (hs) begin
          if (x_q == XMAX_C) begin
            x_d = XMIN_C;
            y_d = y_q - 16'sd1;
          end else begin
            x_d = x_q + 16'sd1;
          end
        end
        if (hs && last_beat) begin
          state_d = DRAIN;
          valid_d = 1'b0;
        end else begin
          // A stalled beat never loses credit, so this holds valid steady.
          valid_d = credit_ok;
        end
      end

      DRAIN: begin
        valid_d = 1'b0;
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (inflight_q == 6'd0) begin
          fd_d = 1'b1;
          if (continuous && !(stop_pending_q || stop)) begin
            state_d = RUN;
            x_d     = XMIN_C;
            y_d     = YTOP_C;
            valid_d = credit_ok;
            fs_d    = 1'b1;
          end else begin
            state_d        = IDLE;
            stop_pending_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign m_axis.m_tvalid = valid_q;
  assign m_axis.m_tdata  = valid_q ? {y_q <<< 3, x_q <<< 3} : 32'd0;
  assign frame_start     = fs_q;
  assign frame_done      = fd_q;
  assign busy            = (state_q != IDLE);
  assign inflight        = inflight_q;
  assign err_underflow   = err_q;

endmodule
